aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
// - Iterative AES encrypt core. Sits directly downstream of aes_roundkey_gen: drives its round/mode inputs,
//   consumes round_key and applies one AES round per round step to a 128-bit state register.
// - Ready/valid handshake on the plaintext input and on the ciphertext output. AES-128/192/256 per block.
// PARAMETERS
// - RK_LAT  default 1  cycles from a change on rk_round to a valid rk_key (aes_roundkey_gen pipe latency); legal 0..3
// PORTS
// - clk        in   1    clock, all logic on rising edge
// - reset      in   1    synchronous, active-high reset
// - in_valid   in   1    plaintext block present
// - in_ready   out  1    sequencer can accept a block
// - in_mode    in   2    00 AES-128, 01 AES-192, 10 AES-256, 11 illegal
// - in_data    in   128  plaintext, byte 0 at [127:120]
// - rk_mode    out  2    mode to aes_roundkey_gen (latched copy of in_mode)
// - rk_round   out  4    round index to aes_roundkey_gen
// - rk_key     in   128  round key returned for rk_round
// - out_valid  out  1    ciphertext valid
// - out_ready  in   1    consumer accepts ciphertext
// - out_data   out  128  ciphertext
// - err        out  1    one-cycle pulse: illegal mode rejected
// - busy       out  1    high in every state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=1, out_valid=0, err=0, busy=0, rk_round=0, rk_mode=0, out_data=0, state reg=0.
// - Nr = 10/12/14 for mode 00/01/10. Mode is latched at accept and held on rk_mode until the block leaves.
// - FSM states: IDLE, KWAIT, APPLY, DONE.
// - IDLE: in_ready=1. On in_valid&in_ready with mode!=11: latch data/mode, rk_round=0, cnt=RK_LAT -> KWAIT
//   (go to APPLY directly if RK_LAT=0).
// - IDLE, illegal mode: accept/drop the block, pulse err for 1 cycle, remain IDLE.
// - KWAIT: decrement cnt; at cnt==1 -> APPLY. rk_round is held stable throughout.
// - APPLY, round r:
//   - r==0: st ^= rk_key.
//   - 1<=r<Nr: st = MixColumns(ShiftRows(SubBytes(st))) ^ rk_key.
//   - r==Nr: st = ShiftRows(SubBytes(st)) ^ rk_key, then -> DONE.
//   - Otherwise rk_round=r+1, reload cnt -> KWAIT.
// - SubBytes: 16 instances of the codebase aes_sbox. MixColumns: GF(2^8) xtime, poly 0x11B.
// - Latency: (Nr+1)*(RK_LAT+1) cycles from accept edge to out_valid rising. RK_LAT=1: 22/26/30 cycles.
// - DONE: out_valid=1; out_data = st, stable until out_valid&out_ready, then -> IDLE.
//   in_ready=0 in DONE (no overlap); re-accept is possible on the cycle after the output handshake.
// - out_valid is never withdrawn without out_ready. in_ready=0 in KWAIT/APPLY/DONE.
// - Reset asserted mid-operation: abort on that edge, all outputs return to reset values, no out_valid produced.
// - rk_round never exceeds Nr. Nr=14 fits 4 bits; no wrap.
// CONFIGURATION
// - AES_SEQ_ZEROIZE_EN defined:
//   - st and out_data cleared to 0 on the cycle after the out handshake and on illegal-mode reject.
//   - Latched in_data cleared on reject.
// - Not defined: st/out_data retain the last ciphertext until the next block overwrites them.
// - Handshakes and latency are identical in both builds.
// TESTING
// - All vectors use RK_LAT=1 with aes_roundkey_gen connected.
// - AES-128: key 000102..0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a,
//   out_valid exactly 22 cycles after accept.
// - AES-192: key 000102..17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 after 26 cycles.
// - AES-256: key 000102..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089 after 30 cycles.
// - Backpressure: out_ready=0 for 5 cycles at DONE -> out_data/out_valid stable, in_ready=0.
//   Raise out_ready -> handshake; next in_valid accepted on the following cycle.
// - in_mode=11 with in_valid=1 -> err pulses one cycle, busy stays 0, no out_valid.
//   With AES_SEQ_ZEROIZE_EN, out_data==0.
// - reset pulsed at round 5 of an AES-256 block -> next cycle all outputs at reset values.
//   A following AES-128 block still yields 69c4e0d8...c55a.

Source files
------------

// File: rtl/aes_round_sequencer_if.sv
// Bundled plaintext/ciphertext handshakes and the round-key side channel of aes_round_sequencer.
// The master side is the block feeding plaintext, consuming ciphertext and returning round keys.
interface aes_round_sequencer_if;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_mode;
   logic [127:0] in_data;
   logic [1:0]   rk_mode;
   logic [3:0]   rk_round;
   logic [127:0] rk_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         err;
   logic         busy;

   modport master (
      output in_valid, in_mode, in_data, rk_key, out_ready,
      input  in_ready, rk_mode, rk_round, out_valid, out_data, err, busy
   );

   modport slave (
      input  in_valid, in_mode, in_data, rk_key, out_ready,
      output in_ready, rk_mode, rk_round, out_valid, out_data, err, busy
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128/192/256 encrypt core, one round per key-wait/apply step against aes_roundkey_gen.
// Build macro AES_SEQ_ZEROIZE_EN: wipe state and ciphertext after hand-off and on illegal-mode reject.
module aes_round_sequencer #(
   parameter int unsigned RK_LAT = 1
) (
   input logic                  clk,
   input logic                  reset,
   aes_round_sequencer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StKwait, StApply, StDone} state_e;

   // Forward S-box, byte 0x00 in the top byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [1:0] CntReload = 2'(RK_LAT);
   localparam state_e     StWait    = (RK_LAT == 0) ? StApply : StKwait;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] base;
      base = {~x, 3'b000};
      return SBOX[base +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = sbox(s[8*i +: 8]);
      end
      return r;
   endfunction

   // Byte b sits at [127-8b -: 8]; row = b%4, column = b/4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   state_e       state_q, state_d;
   logic [127:0] st_q, st_d;
   logic [127:0] out_data_q, out_data_d;
   logic [1:0]   mode_q, mode_d;
   logic [3:0]   round_q, round_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         err_q, err_d;

   logic [3:0]   nr;
   logic [127:0] sb_sr;
   logic [127:0] rnd_mid;
   logic [127:0] rnd_last;

   always_comb begin
      unique case (mode_q)
         2'd0:    nr = 4'd10;
         2'd1:    nr = 4'd12;
         default: nr = 4'd14;
      endcase
   end

   assign sb_sr    = shift_rows(sub_bytes(st_q));
   assign rnd_mid  = mix_columns(sb_sr) ^ bus.rk_key;
   assign rnd_last = sb_sr ^ bus.rk_key;

   always_comb begin
      state_d    = state_q;
      st_d       = st_q;
      out_data_d = out_data_q;
      mode_d     = mode_q;
      round_d    = round_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               if (bus.in_mode == 2'b11) begin
                  err_d = 1'b1;
`ifdef AES_SEQ_ZEROIZE_EN
                  st_d       = '0;
                  out_data_d = '0;
`endif
               end else begin
                  st_d    = bus.in_data;
                  mode_d  = bus.in_mode;
                  round_d = 4'd0;
                  cnt_d   = CntReload;
                  state_d = StWait;
               end
            end
         end
         StKwait: begin
            if (cnt_q <= 2'd1) begin
               state_d = StApply;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         StApply: begin
            if (round_q == 4'd0) begin
               st_d = st_q ^ bus.rk_key;
            end else if (round_q == nr) begin
               st_d = rnd_last;
            end else begin
               st_d = rnd_mid;
            end
            if (round_q == nr) begin
               out_data_d = rnd_last;
               state_d    = StDone;
            end else begin
               round_d = round_q + 4'd1;
               cnt_d   = CntReload;
               state_d = StWait;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
`ifdef AES_SEQ_ZEROIZE_EN
               st_d       = '0;
               out_data_d = '0;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         st_q       <= '0;
         out_data_q <= '0;
         mode_q     <= 2'd0;
         round_q    <= 4'd0;
         cnt_q      <= 2'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         st_q       <= st_d;
         out_data_q <= out_data_d;
         mode_q     <= mode_d;
         round_q    <= round_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.busy      = (state_q != StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.out_data  = out_data_q;
   assign bus.rk_mode   = mode_q;
   assign bus.rk_round  = round_q;
   assign bus.err       = err_q;

   out_hold_a: assert property (@(posedge clk) disable iff (reset)
      bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_data));

   round_range_a: assert property (@(posedge clk) disable iff (reset)
      bus.busy |-> bus.rk_round <= nr);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: emulates aes_roundkey_gen (RK_LAT=1) and checks every cycle
// against a block-level AES model plus FIPS-197 literal vectors.
module tb_aes_round_sequencer;

   localparam int unsigned RK_LAT = 1;

   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   aes_round_sequencer_if bus ();

   aes_round_sequencer #(.RK_LAT(RK_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   logic [7:0]   sbox_t [256];
   logic [127:0] sched  [3][15];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic int nr_of(input int mode);
      return 10 + 2 * mode;
   endfunction

   // S-box from the definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                     ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   task automatic expand(input int mode, input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] tmp;
      logic [7:0]  rc;
      int          nk;
      int          nr;
      nk = 4 + 2 * mode;
      nr = nr_of(mode);
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            tmp = sub_word(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int r = 0; r < 15; r++) begin
         sched[mode][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      end
   endtask

   function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input int mode);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a [4];
      logic [127:0] k;
      logic [127:0] res;
      int           nr;
      nr = nr_of(mode);
      k  = sched[mode][0];
      for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
         for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
               s[row + 4*col] = t[row + 4*((col + row) % 4)];
         if (r < nr) begin
            for (int col = 0; col < 4; col++) begin
               for (int j = 0; j < 4; j++) a[j] = s[4*col + j];
               s[4*col+0] = gmul(8'h02, a[0]) ^ gmul(8'h03, a[1]) ^ a[2] ^ a[3];
               s[4*col+1] = a[0] ^ gmul(8'h02, a[1]) ^ gmul(8'h03, a[2]) ^ a[3];
               s[4*col+2] = a[0] ^ a[1] ^ gmul(8'h02, a[2]) ^ gmul(8'h03, a[3]);
               s[4*col+3] = gmul(8'h03, a[0]) ^ a[1] ^ a[2] ^ gmul(8'h02, a[3]);
            end
         end
         k = sched[mode][r];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
      return res;
   endfunction

   // Round-key generator stand-in: one register stage from (mode, round) to key.
   always @(posedge clk) begin
      if (bus.rk_mode != 2'd3 && bus.rk_round < 4'd15)
         bus.rk_key <= sched[int'(bus.rk_mode)][int'(bus.rk_round)];
      else
         bus.rk_key <= '0;
   end

   // Block-level model: a block occupies the core for (Nr+1)*(RK_LAT+1) cycles, then waits.
   bit           m_busy = 1'b0;
   int           m_cnt  = 0;
   bit           m_err  = 1'b0;
   logic [1:0]   m_mode = 2'd0;
   logic [127:0] m_out  = '0;
   logic [127:0] m_ct   = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_busy = 1'b0;
         m_cnt  = 0;
         m_err  = 1'b0;
         m_mode = 2'd0;
         m_out  = '0;
      end else begin
         m_err = 1'b0;
         if (!m_busy) begin
            if (bus.in_valid) begin
               if (bus.in_mode == 2'b11) begin
                  m_err = 1'b1;
`ifdef AES_SEQ_ZEROIZE_EN
                  m_out = '0;
`endif
               end else begin
                  m_busy = 1'b1;
                  m_mode = bus.in_mode;
                  m_cnt  = (nr_of(int'(bus.in_mode)) + 1) * (RK_LAT + 1);
                  m_ct   = model_encrypt(bus.in_data, int'(bus.in_mode));
               end
            end
         end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_out = m_ct;
         end else if (bus.out_ready) begin
            m_busy = 1'b0;
`ifdef AES_SEQ_ZEROIZE_EN
            m_out = '0;
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_in_ready", 128'(bus.in_ready), 128'(!m_busy));
         check("cyc_busy", 128'(bus.busy), 128'(m_busy));
         check("cyc_out_valid", 128'(bus.out_valid), 128'(m_busy && m_cnt == 0));
         check("cyc_err", 128'(bus.err), 128'(m_err));
         check("cyc_out_data", bus.out_data, m_out);
         check("cyc_rk_mode", 128'(bus.rk_mode), 128'(m_mode));
         if (m_busy) check("cyc_rk_round_le_nr", 128'(int'(bus.rk_round) <= nr_of(int'(m_mode))),
                           128'(1));
      end
   end

   task automatic wait_ready();
      int k;
      k = 0;
      while (!bus.in_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) check("wait_in_ready_timeout", 128'(0), 128'(1));
   endtask

   task automatic run_block(input logic [1:0] mode, input logic [127:0] exp_ct,
                            input int exp_lat, input int bp);
      int k;
      wait_ready();
      bus.out_ready = (bp == 0);
      bus.in_valid  = 1'b1;
      bus.in_mode   = mode;
      bus.in_data   = PT;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      k = 0;
      while (!bus.out_valid && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check($sformatf("latency_mode%0d", mode), 128'(k), 128'(exp_lat));
      check($sformatf("ct_mode%0d", mode), bus.out_data, exp_ct);
      if (bp > 0) begin
         // Offer another block while the result is held; it must not be taken.
         bus.in_valid = 1'b1;
         bus.in_mode  = 2'd0;
         for (int i = 0; i < bp; i++) begin
            check("bp_out_valid", 128'(bus.out_valid), 128'(1));
            check("bp_out_data", bus.out_data, exp_ct);
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
            @(posedge clk); #1;
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         check("bp_after_hs_out_valid", 128'(bus.out_valid), 128'(0));
         check("bp_after_hs_in_ready", 128'(bus.in_ready), 128'(1));
      end
   endtask

   initial begin
      int k;
      bus.in_valid  = 1'b0;
      bus.in_mode   = 2'd0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      build_sbox();
      expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
      expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
      expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

      check("model_ct128", model_encrypt(PT, 0), CT128);
      check("model_ct192", model_encrypt(PT, 1), CT192);
      check("model_ct256", model_encrypt(PT, 2), CT256);

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 128'(bus.in_ready), 128'(1));
      check("rst_out_valid", 128'(bus.out_valid), 128'(0));
      check("rst_err", 128'(bus.err), 128'(0));
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_rk_round", 128'(bus.rk_round), 128'(0));
      check("rst_rk_mode", 128'(bus.rk_mode), 128'(0));
      check("rst_out_data", bus.out_data, 128'(0));
      reset  = 1'b0;
      chk_en = 1'b1;

      run_block(2'd0, CT128, 22, 0);
      run_block(2'd1, CT192, 26, 0);
      run_block(2'd2, CT256, 30, 0);
      run_block(2'd0, CT128, 22, 5);
      run_block(2'd1, CT192, 26, 0);

      // Illegal mode is dropped with a single err pulse.
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_mode  = 2'b11;
      bus.in_data  = PT;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_mode  = 2'd0;
      check("ill_err", 128'(bus.err), 128'(1));
      check("ill_busy", 128'(bus.busy), 128'(0));
      check("ill_in_ready", 128'(bus.in_ready), 128'(1));
`ifdef AES_SEQ_ZEROIZE_EN
      check("ill_zeroized", bus.out_data, 128'(0));
`endif
      @(posedge clk); #1;
      check("ill_err_cleared", 128'(bus.err), 128'(0));
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of an AES-256 block.
      wait_ready();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_mode   = 2'd2;
      bus.in_data   = PT;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      k = 0;
      while (bus.rk_round != 4'd5 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("mid_reach_round5", 128'(k < 100), 128'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
      check("mid_rst_busy", 128'(bus.busy), 128'(0));
      check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
      check("mid_rst_err", 128'(bus.err), 128'(0));
      check("mid_rst_rk_round", 128'(bus.rk_round), 128'(0));
      check("mid_rst_rk_mode", 128'(bus.rk_mode), 128'(0));
      check("mid_rst_out_data", bus.out_data, 128'(0));
      repeat (40) @(posedge clk);
      #1;
      run_block(2'd0, CT128, 22, 0);

      repeat (4) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required end before 200000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
